// File: rtl/fsram_dp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fsram_dp_pkg
// Description : Shared definitions for the FSRAM data-process block:
//               - op-code values and their widths
//               - a helper that maps an op code to the number of window
//                 entries it shifts in
//               - a helper that maps an op code to the number of zero
//                 pixels it inserts
// Revision    : 1.0 - initial release
// ============================================================================
package fsram_dp_pkg;

    localparam int DP_CODE_W = 3;
    localparam int FILL_W    = 2;

    localparam logic [DP_CODE_W-1:0] DP_IDLE    = 3'd0;
    localparam logic [DP_CODE_W-1:0] DP_ZERO3   = 3'd1;
    localparam logic [DP_CODE_W-1:0] DP_PADF    = 3'd2;
    localparam logic [DP_CODE_W-1:0] DP_PADB    = 3'd3;
    localparam logic [DP_CODE_W-1:0] DP_ZERO1   = 3'd4;
    localparam logic [DP_CODE_W-1:0] DP_FRONT   = 3'd5;
    localparam logic [DP_CODE_W-1:0] DP_BACK    = 3'd6;
    localparam logic [DP_CODE_W-1:0] DP_ILLEGAL = 3'd7;

    // Number of entries a code pushes into the window (0 = no shift).
    function automatic logic [FILL_W-1:0] dp_shift_cnt(input logic [DP_CODE_W-1:0] code);
        logic [FILL_W-1:0] cnt;
        cnt = '0;
        case (code)
            DP_ZERO3:                     cnt = 2'd3;
            DP_PADF, DP_PADB:             cnt = 2'd2;
            DP_ZERO1, DP_FRONT, DP_BACK:  cnt = 2'd1;
            default:                      cnt = 2'd0;
        endcase
        return cnt;
    endfunction

    // Number of zero pixels a code inserts into the window.
    function automatic logic [1:0] dp_zero_ins(input logic [DP_CODE_W-1:0] code);
        logic [1:0] cnt;
        cnt = '0;
        case (code)
            DP_ZERO3:                     cnt = 2'd3;
            DP_PADF, DP_PADB, DP_ZERO1:   cnt = 2'd1;
            default:                      cnt = 2'd0;
        endcase
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fsram_dp_lane.sv
`default_nettype none
// ============================================================================
// Module      : fsram_dp_lane
// Description : One lane's 3-pixel row window. Splits the 16-bit SRAM word
//               into front [15:8] and back [7:0] pixels and shifts them,
//               or zero padding, into the window according to the op code.
// Ports       : clk, rst_n      - clock, async active-low reset
//               word           - selected SRAM word for this lane
//               code           - delayed op code (applies this cycle)
//               win            - window; top pixel oldest, bottom newest
// Revision    : 1.0 - initial release
// ============================================================================
module fsram_dp_lane
    import fsram_dp_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          word,
    input  logic [DP_CODE_W-1:0] code,
    output logic [3*PIX_W-1:0]   win
);

    localparam logic [PIX_W-1:0] c_zero = '0;

    logic [3*PIX_W-1:0] r_win;
    logic [3*PIX_W-1:0] w_win_next;
    logic [PIX_W-1:0]   w_front;
    logic [PIX_W-1:0]   w_back;

    assign w_front = word[15 -: PIX_W];
    assign w_back  = word[PIX_W-1:0];

    // Two-entry codes drop the two oldest pixels; the first listed entry
    // lands in the middle slot so it ends up older than the second.
    always_comb begin
        w_win_next = r_win;
        case (code)
            DP_ZERO3: w_win_next = '0;
            DP_PADF:  w_win_next = {r_win[PIX_W-1:0], c_zero, w_front};
            DP_PADB:  w_win_next = {r_win[PIX_W-1:0], w_back, c_zero};
            DP_ZERO1: w_win_next = {r_win[2*PIX_W-1:0], c_zero};
            DP_FRONT: w_win_next = {r_win[2*PIX_W-1:0], w_front};
            DP_BACK:  w_win_next = {r_win[2*PIX_W-1:0], w_back};
            default:  w_win_next = r_win;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win <= '0;
        end else begin
            r_win <= w_win_next;
        end
    end

    assign win = r_win;

endmodule
`default_nettype wire

// File: rtl/fsram_data_proc.sv
`default_nettype none
// ============================================================================
// Module      : fsram_data_proc
// Description : Consumes the FSRAM pair read data. Stage 0 registers the
//               op code and bank/port select alongside the SRAM read
//               address; stage 1 muxes the returned word and updates
//               SRAM_NUM lane windows, the fill counter and flags.
// Ports       : clk, rst_n          - clock, async active-low reset
//               data_process_reg    - op code (same cycle as read address)
//               sram_sel1/sram_sel2 - bank (FSRAM1/2) and port (A/B) select
//               QA_1/QB_1/QA_2/QB_2 - FSRAM read data, SRAM_NUM*16 bits
//               win_out             - lane windows, lane i at [i*3*PIX_W +:]
//               win_valid           - window updated and full
//               code_err            - sticky illegal-code flag
//               zero_cnt            - inserted zero-pixel count (only with
//                                     FSRAM_DP_ZERO_CNT_EN defined)
// Revision    : 1.0 - initial release
// ============================================================================
module fsram_data_proc
    import fsram_dp_pkg::*;
#(
    parameter int SRAM_NUM = 16,
    parameter int PIX_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DP_CODE_W-1:0]        data_process_reg,
    input  logic                        sram_sel1,
    input  logic                        sram_sel2,
    input  logic [SRAM_NUM*16-1:0]      QA_1,
    input  logic [SRAM_NUM*16-1:0]      QB_1,
    input  logic [SRAM_NUM*16-1:0]      QA_2,
    input  logic [SRAM_NUM*16-1:0]      QB_2,
    output logic [SRAM_NUM*3*PIX_W-1:0] win_out,
    output logic                        win_valid,
    output logic                        code_err
`ifdef FSRAM_DP_ZERO_CNT_EN
    ,
    output logic [15:0]                 zero_cnt
`endif
);

    localparam int LANE_W = 3 * PIX_W;

    logic [DP_CODE_W-1:0]   r_code_d;
    logic [1:0]             r_sel_d;
    logic [FILL_W-1:0]      r_fill;
    logic                   r_win_valid;
    logic                   r_code_err;

    logic [SRAM_NUM*16-1:0] w_q;
    logic [FILL_W-1:0]      w_shift;
    logic [FILL_W:0]        w_fill_sum;
    logic [FILL_W-1:0]      w_fill_next;

    // Stage 0: align code and select with the one-cycle SRAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code_d <= DP_IDLE;
            r_sel_d  <= '0;
        end else begin
            r_code_d <= data_process_reg;
            r_sel_d  <= {sram_sel1, sram_sel2};
        end
    end

    // Stage 1: one select for all lanes, so lanes never mix banks/ports.
    always_comb begin
        w_q = QA_1;
        case (r_sel_d)
            2'b00:   w_q = QA_1;
            2'b01:   w_q = QB_1;
            2'b10:   w_q = QA_2;
            default: w_q = QB_2;
        endcase
    end

    generate
        for (genvar gi = 0; gi < SRAM_NUM; gi++) begin : g_lane
            fsram_dp_lane #(
                .PIX_W (PIX_W)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .word  (w_q[gi*16 +: 16]),
                .code  (r_code_d),
                .win   (win_out[gi*LANE_W +: LANE_W])
            );
        end
    endgenerate

    // Fill saturates at 3; the carry bit of the sum flags overflow.
    assign w_shift    = dp_shift_cnt(r_code_d);
    assign w_fill_sum = {1'b0, r_fill} + {1'b0, w_shift};

    always_comb begin
        w_fill_next = r_fill;
        if (r_code_d == DP_ZERO3) begin
            w_fill_next = {FILL_W{1'b1}};
        end else if (w_fill_sum[FILL_W]) begin
            w_fill_next = {FILL_W{1'b1}};
        end else begin
            w_fill_next = w_fill_sum[FILL_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fill      <= '0;
            r_win_valid <= 1'b0;
            r_code_err  <= 1'b0;
        end else begin
            r_fill      <= w_fill_next;
            r_win_valid <= (w_shift != '0) && (w_fill_next == {FILL_W{1'b1}});
            r_code_err  <= r_code_err | (r_code_d == DP_ILLEGAL);
        end
    end

    assign win_valid = r_win_valid;
    assign code_err  = r_code_err;

`ifdef FSRAM_DP_ZERO_CNT_EN
    logic [15:0] r_zero_cnt;

    // Wraps modulo 2^16 by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_cnt <= '0;
        end else begin
            r_zero_cnt <= r_zero_cnt + {14'd0, dp_zero_ins(r_code_d)};
        end
    end

    assign zero_cnt = r_zero_cnt;
`else
    // Zero-pixel counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsram_data_proc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fsram_data_proc
// Description : Self-checking bench for fsram_data_proc. Each issued code
//               pushes its expected lane-0 / last-lane window, win_valid,
//               code_err (and zero_cnt) into a scoreboard queue, popped two
//               cycles later when the DUT result is due.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fsram_data_proc;
    import fsram_dp_pkg::*;

    localparam int N  = 16;
    localparam int PW = 8;
    localparam int LW = 3 * PW;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        dpr = 3'd0;
    logic              s1 = 1'b0;
    logic              s2 = 1'b0;
    logic [N*16-1:0]   qa1 = '0, qb1 = '0, qa2 = '0, qb2 = '0;
    logic [N*16-1:0]   p_qa1 = '0, p_qb1 = '0, p_qa2 = '0, p_qb2 = '0;
    wire  [N*LW-1:0]   win_out;
    wire               win_valid;
    wire               code_err;
`ifdef FSRAM_DP_ZERO_CNT_EN
    wire  [15:0]       zero_cnt;
`endif

    fsram_data_proc #(
        .SRAM_NUM (N),
        .PIX_W    (PW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .data_process_reg (dpr),
        .sram_sel1        (s1),
        .sram_sel2        (s2),
        .QA_1             (qa1),
        .QB_1             (qb1),
        .QA_2             (qa2),
        .QB_2             (qb2),
        .win_out          (win_out),
        .win_valid        (win_valid),
        .code_err         (code_err)
`ifdef FSRAM_DP_ZERO_CNT_EN
        ,
        .zero_cnt         (zero_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [23:0] w0;
        logic [23:0] wn;
        logic        v;
        logic        e;
        logic [15:0] zc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model state
    logic [23:0] m_w0, m_wn;
    logic [1:0]  m_fill;
    logic        m_err;
    logic [15:0] m_zc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*16-1:0] rnd_bus();
        logic [N*16-1:0] v;
        for (int i = 0; i < N / 2; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Window behaviour written directly from the op-code table.
    function automatic logic [23:0] m_next(input logic [23:0] w, input logic [2:0] c,
                                           input logic [15:0] word);
        logic [7:0] f, b;
        f = word[15:8];
        b = word[7:0];
        case (c)
            3'd1:    return 24'h0;
            3'd2:    return {w[7:0], 8'h00, f};
            3'd3:    return {w[7:0], b, 8'h00};
            3'd4:    return {w[15:0], 8'h00};
            3'd5:    return {w[15:0], f};
            3'd6:    return {w[15:0], b};
            default: return w;
        endcase
    endfunction

    task automatic model_reset();
        m_w0 = '0; m_wn = '0; m_fill = '0; m_err = 1'b0; m_zc = '0;
    endtask

    task automatic compare_due();
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("win_lane0", 64'(win_out[23:0]), 64'(e.w0));
            check("win_lastlane", 64'(win_out[(N-1)*LW +: LW]), 64'(e.wn));
            check("win_valid", 64'(win_valid), 64'(e.v));
            check("code_err", 64'(code_err), 64'(e.e));
`ifdef FSRAM_DP_ZERO_CNT_EN
            check("zero_cnt", 64'(zero_cnt), 64'(e.zc));
`endif
        end
    endtask

    // One cycle: check due result, present previous code's read data,
    // present a new code and prepare its read data for the next cycle.
    task automatic step(input logic [2:0] c, input logic sa, input logic sb_, input logic [15:0] w0,
                        input bit push);
        logic [N*16-1:0] sel;
        exp_t            e;
        int              add;
        @(negedge clk);
        cyc++;
        compare_due();
        qa1 = p_qa1; qb1 = p_qb1; qa2 = p_qa2; qb2 = p_qb2;
        dpr = c; s1 = sa; s2 = sb_;
        p_qa1 = rnd_bus(); p_qb1 = rnd_bus(); p_qa2 = rnd_bus(); p_qb2 = rnd_bus();
        case ({sa, sb_})
            2'b00:   begin p_qa1[15:0] = w0; sel = p_qa1; end
            2'b01:   begin p_qb1[15:0] = w0; sel = p_qb1; end
            2'b10:   begin p_qa2[15:0] = w0; sel = p_qa2; end
            default: begin p_qb2[15:0] = w0; sel = p_qb2; end
        endcase
        if (push) begin
            m_w0 = m_next(m_w0, c, sel[15:0]);
            m_wn = m_next(m_wn, c, sel[(N-1)*16 +: 16]);
            case (c)
                3'd1:             begin add = 3; m_fill = 2'd3; end
                3'd2, 3'd3:       add = 2;
                3'd4, 3'd5, 3'd6: add = 1;
                default:          add = 0;
            endcase
            if (c != 3'd1) m_fill = (int'(m_fill) + add > 3) ? 2'd3 : 2'(int'(m_fill) + add);
            if (c == 3'd7) m_err = 1'b1;
            if (c == 3'd1) m_zc = m_zc + 16'd3;
            if (c == 3'd2 || c == 3'd3 || c == 3'd4) m_zc = m_zc + 16'd1;
            e.due = cyc + 2;
            e.w0 = m_w0; e.wn = m_wn;
            e.v = (add != 0) && (m_fill == 2'd3);
            e.e = m_err; e.zc = m_zc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            cyc++;
            compare_due();
            qa1 = p_qa1; qb1 = p_qb1; qa2 = p_qa2; qb2 = p_qb2;
            dpr = 3'd0;
        end
        check("sb_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        dpr = 3'd0;
        #1;
        check({tag, "_win"}, 64'(win_out != '0), 64'd0);
        check({tag, "_valid"}, 64'(win_valid), 64'd0);
        check({tag, "_err"}, 64'(code_err), 64'd0);
`ifdef FSRAM_DP_ZERO_CNT_EN
        check({tag, "_zc"}, 64'(zero_cnt), 64'd0);
`endif
        sb.delete();
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check({tag, "_valid_hold"}, 64'(win_valid), 64'd0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_win", 64'(win_out != '0), 64'd0);
        check("rst_valid", 64'(win_valid), 64'd0);
        check("rst_err", 64'(code_err), 64'd0);
`ifdef FSRAM_DP_ZERO_CNT_EN
        check("rst_zc", 64'(zero_cnt), 64'd0);
`endif
        rst_n = 1'b1;

        // ZERO3 from FSRAM1 port B
        step(DP_ZERO3, 1'b0, 1'b1, 16'hABCD, 1'b1);
        drain();
        check("tp_zero3_win", 64'(win_out[23:0]), 64'h000000);
        check("tp_zero3_valid", 64'(win_valid), 64'd1);

        // FRONT then BACK
        step(DP_FRONT, 1'b0, 1'b1, 16'h1234, 1'b1);
        @(negedge clk);
        // interleave by issuing BACK right behind via step keeps pipeline full
        cyc++;
        compare_due();
        qa1 = p_qa1; qb1 = p_qb1; qa2 = p_qa2; qb2 = p_qb2;
        dpr = 3'd0;
        @(negedge clk);
        cyc++;
        compare_due();
        check("tp_front_win", 64'(win_out[23:0]), 64'h000012);
        check("tp_front_valid", 64'(win_valid), 64'd1);
        step(DP_BACK, 1'b0, 1'b1, 16'h5678, 1'b1);
        drain();
        check("tp_back_win", 64'(win_out[23:0]), 64'h001278);
        check("tp_back_valid", 64'(win_valid), 64'd1);

        // Back-to-back random traffic over all codes and selects
        for (int i = 0; i < 60; i++) begin
            step(3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 16'($urandom), 1'b1);
        end
        drain();

        // PADF from FSRAM2 port A after reset, then ZERO1
        do_reset("rst1");
        step(DP_PADF, 1'b1, 1'b0, 16'h9A00, 1'b1);
        drain();
        check("tp_padf_win", 64'(win_out[23:0]), 64'h00009A);
        check("tp_padf_valid", 64'(win_valid), 64'd0);
        step(DP_ZERO1, 1'b1, 1'b0, 16'h5555, 1'b1);
        drain();
        check("tp_zero1_win", 64'(win_out[23:0]), 64'h009A00);
        check("tp_zero1_valid", 64'(win_valid), 64'd1);

        // Illegal code: no shift, sticky error
        step(DP_ILLEGAL, 1'b0, 1'b0, 16'hFFFF, 1'b1);
        drain();
        check("tp_ill_err", 64'(code_err), 64'd1);
        check("tp_ill_win", 64'(win_out[23:0]), 64'h009A00);
        check("tp_ill_valid", 64'(win_valid), 64'd0);
        step(DP_ZERO3, 1'b0, 1'b0, 16'h1111, 1'b1);
        drain();
        check("tp_ill_z3_win", 64'(win_out[23:0]), 64'h000000);
        check("tp_ill_z3_valid", 64'(win_valid), 64'd1);
        check("tp_ill_z3_err", 64'(code_err), 64'd1);

        // Reset one cycle after FRONT: in-flight code dropped
        step(DP_FRONT, 1'b0, 1'b0, 16'h7700, 1'b1);
        step(DP_FRONT, 1'b0, 1'b0, 16'h3300, 1'b1);
        drain();
        step(DP_FRONT, 1'b0, 1'b0, 16'hEE00, 1'b0);
        do_reset("rst_mid");
        step(DP_PADF, 1'b1, 1'b0, 16'h9A00, 1'b1);
        drain();
        check("tp_fresh_win", 64'(win_out[23:0]), 64'h00009A);
        check("tp_fresh_valid", 64'(win_valid), 64'd0);

`ifdef FSRAM_DP_ZERO_CNT_EN
        do_reset("rst_zc");
        step(DP_ZERO3, 1'b0, 1'b0, 16'h0101, 1'b1);
        step(DP_PADB,  1'b0, 1'b0, 16'h0202, 1'b1);
        step(DP_PADF,  1'b0, 1'b0, 16'h0303, 1'b1);
        step(DP_FRONT, 1'b0, 1'b0, 16'h0404, 1'b1);
        drain();
        check("tp_zc_five", 64'(zero_cnt), 64'd5);
        do_reset("rst_wrap");
        for (int i = 0; i < 21845; i++) step(DP_ZERO3, 1'b0, 1'b0, 16'h0000, 1'b1);
        drain();
        check("tp_zc_ffff", 64'(zero_cnt), 64'hFFFF);
        step(DP_ZERO1, 1'b0, 1'b0, 16'h0000, 1'b1);
        drain();
        check("tp_zc_wrap", 64'(zero_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fsram_data_proc.md
# fsram_data_proc

Downstream consumer of the FSRAM pair that `sram_controller` fills. Each cycle it takes the controller's data-process code and SRAM select, picks the addressed FSRAM read port, and aligns the result to the one-cycle SRAM read latency. It then splits each 16-bit SRAM word into front/back pixels and inserts zero padding. The result is shifted into a per-lane 3-pixel row window that feeds the CCM.

## Interface
- `SRAM_NUM`, default 16: number of FSRAM macros (lanes) per bank, each 16 bits wide.
- `PIX_W`, default 8: pixel width. Each 16-bit SRAM word holds a front pixel [15:8] and a back pixel [7:0].
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_process_reg`  in  3  per-cycle op code from `sram_controller`, issued in the same cycle as the SRAM read address.
- `sram_sel1`  in  1  bank select: 0 = FSRAM1, 1 = FSRAM2.
- `sram_sel2`  in  1  port select: 0 = port A (QA), 1 = port B (QB).
- `QA_1`, `QB_1`, `QA_2`, `QB_2`  in  SRAM_NUM*16 each  FSRAM read data.
- `win_out`  out  SRAM_NUM*3*PIX_W  per-lane windows. Lane i occupies [i*24 +: 24]. Within a lane, [23:16] is the oldest pixel and [7:0] the newest.
- `win_valid`  out  1  high for one cycle when `win_out` was updated and the window is full.
- `code_err`  out  1  sticky flag for an illegal code.

## Operation
- Op codes:
  - 0 = IDLE: no shift.
  - 1 = ZERO3: load 0,0,0.
  - 2 = PADF: shift in 0, then front.
  - 3 = PADB: shift in back, then 0.
  - 4 = ZERO1: shift in 0.
  - 5 = FRONT: shift in front.
  - 6 = BACK: shift in back.
  - 7 = illegal.
- Multi-entry shifts insert in the listed order, so the first listed entry ends up older.
- Stage 0 (code cycle): register `data_process_reg`, `sram_sel1` and `sram_sel2` into `code_d`/`sel_d`.
- Stage 1 (data cycle):
  - Mux Q by `sel_d`.
  - Apply `code_d` identically to every lane.
  - Update the window registers.
- Fill counter `fill` (0..3, saturating):
  - ZERO3 sets it to 3.
  - Other shifting codes add 1 or 2 each, capped at 3.
  - IDLE and illegal codes leave it unchanged.
- `win_valid` is registered. It is 1 iff stage 1 performed a shift and the updated fill is 3.
- Illegal code 7 behaves as IDLE and sets `code_err`. `code_err` clears only on reset.
- Selection applies to all lanes at once; lanes never mix banks or ports.

## Timing
- Reset values: `win_out`=0, `win_valid`=0, `code_err`=0, `fill`=0, `code_d`=IDLE, `sel_d`=0, `zero_cnt`=0.
- Latency: code sampled at edge t; Q is valid during t..t+1; the window updates at edge t+1. `win_out` and `win_valid` are therefore visible 2 cycles after the code is presented.
- Throughput: one code per cycle, no stalls. Back-to-back codes pipeline without bubbles.
- Reset mid-operation: an in-flight `code_d` is dropped and no `win_valid` pulse is emitted for it.
- PADF or PADB at fill 2 saturates to 3. The oldest pixels fall out of the window normally.
- ZERO3 following any code overrides the window entirely, and `win_valid` is 1 on that update.

## Configuration
- `FSRAM_DP_ZERO_CNT_EN` defined:
  - Adds output `zero_cnt`, 16 bits, counting zero pixels inserted by padding: +3 for ZERO3, +1 each for PADF, PADB and ZERO1.
  - The counter wraps modulo 2^16 and resets to 0.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `fsram_dp_pkg`:
  - Op-code localparams `DP_IDLE`..`DP_BACK`.
  - `DP_CODE_W`=3 and `FILL_W`=2.
  - A shift-count function mapping code to 0..3.
- Sub-module `fsram_dp_lane`: one lane's 3-entry window, taking the 16-bit word and `code_d`. It is generated SRAM_NUM times.
- The top level holds the stage-0 registers, the Q mux, the fill counter, `win_valid`, `code_err` and the optional counter.

## Test plan
- Reset, then ZERO3 with FSRAM1/B, lane 0 QB_1=16'hABCD → at +2 cycles lane 0 `win_out`=24'h000000 and `win_valid`=1.
- After ZERO3, FRONT with QB_1 lane0=16'h1234, then BACK with 16'h5678 → windows 00_00_12 then 00_12_78, each with `win_valid`=1.
- After reset: PADF with QA_2 lane0=16'h9A00 (sel1=1, sel2=0) → window 00_00_9A, fill 2, `win_valid`=0. Then ZERO1 → 00_9A_00, `win_valid`=1.
- Code 7 → `code_err`=1, window and fill unchanged. A following ZERO3 still works and `code_err` stays 1 until `rst_n` is pulsed.
- Assert `rst_n`=0 one cycle after issuing FRONT → no `win_valid` and all outputs 0. The first code after release behaves as from a fresh reset.
- With `FSRAM_DP_ZERO_CNT_EN`: ZERO3, PADB, PADF, FRONT → `zero_cnt`=5. Preload 16'hFFFF and issue ZERO1 → `zero_cnt` wraps to 0.
